// File: rtl/mfp_loader_status_pkg.sv
// Shared constants, message identifiers and ASCII helpers for the loader status reporter.
package mfp_loader_status_pkg;

    localparam logic [7:0] AsciiL  = 8'h4C;
    localparam logic [7:0] AsciiO  = 8'h4F;
    localparam logic [7:0] AsciiK  = 8'h4B;
    localparam logic [7:0] AsciiE  = 8'h45;
    localparam logic [7:0] AsciiF  = 8'h46;
    localparam logic [7:0] AsciiC  = 8'h43;
    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;

    // Enum values double as bit positions in the pending-flag vector.
    typedef enum logic [1:0] {
        MsgStart = 2'd0,
        MsgDone  = 2'd1,
        MsgFerr  = 2'd2,
        MsgCerr  = 2'd3
    } msg_id_e;

    localparam logic [2:0] LenStart = 3'd3;
    localparam logic [2:0] LenDone  = 3'd4;
    localparam logic [2:0] LenErr   = 3'd6;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

    function automatic logic [2:0] msg_len(input msg_id_e id);
        logic [2:0] len;
        unique case (id)
            MsgStart: len = LenStart;
            MsgDone:  len = LenDone;
            default:  len = LenErr;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter, LSB first, idle high; byte_ready also rises in the last stop-bit
// cycle so a queued byte follows with no idle gap.
module mfp_uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            bit_done;

    assign bit_done = (cnt_q == CntLast);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        data_d     = data_q;
        byte_ready = 1'b0;
        tx         = 1'b1;
        if (state_q != TxIdle) begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            TxIdle:  byte_ready = 1'b1;
            TxStart: begin
                tx = 1'b0;
                if (bit_done) state_d = TxData;
            end
            TxData: begin
                tx = data_q[bit_q];
                if (bit_done) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TxStop;
                end
            end
            TxStop:  byte_ready = bit_done;
            default: state_d = TxIdle;
        endcase
        if (byte_ready && byte_valid) begin
            state_d = TxStart;
            cnt_d   = '0;
            data_d  = byte_data;
        end else if (state_q == TxStop && bit_done) begin
            state_d = TxIdle;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mfp_loader_status_reporter.sv
// Turns loader progress/error edges into short ASCII status lines on the UART TX pin.
module mfp_loader_status_reporter
    import mfp_loader_status_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       in_progress,
    input  logic       format_error,
    input  logic       checksum_error,
    input  logic [7:0] error_location,
    output logic       UART_TX,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} fsm_state_e;

    logic       in_progress_q, in_progress_qq;
    logic       format_error_q, format_error_qq;
    logic       checksum_error_q, checksum_error_qq;
    logic [7:0] error_location_q;

    fsm_state_e state_q, state_d;
    msg_id_e    msg_q, msg_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] pend_q, pend_d;
    logic [7:0] ferr_loc_q, ferr_loc_d;
    logic [7:0] cerr_loc_q, cerr_loc_d;
    logic [7:0] cur_loc_q, cur_loc_d;
    logic [3:0] events, clr;
    logic       byte_valid, byte_ready;
    logic [7:0] byte_data;

    function automatic logic [7:0] msg_char(input msg_id_e id, input logic [2:0] idx,
                                            input logic [7:0] loc);
        logic [7:0] c;
        c = AsciiLf;
        unique case (id)
            MsgStart: begin
                if (idx == 3'd0) c = AsciiL;
                else if (idx == 3'd1) c = AsciiCr;
            end
            MsgDone: begin
                if (idx == 3'd0) c = AsciiO;
                else if (idx == 3'd1) c = AsciiK;
                else if (idx == 3'd2) c = AsciiCr;
            end
            default: begin
                case (idx)
                    3'd0:    c = AsciiE;
                    3'd1:    c = (id == MsgFerr) ? AsciiF : AsciiC;
                    3'd2:    c = hex_ascii(loc[7:4]);
                    3'd3:    c = hex_ascii(loc[3:0]);
                    3'd4:    c = AsciiCr;
                    default: c = AsciiLf;
                endcase
            end
        endcase
        return c;
    endfunction

    // DONE is suppressed when an error is up in the same cycle the loader drops busy.
    assign events[MsgStart] = in_progress_q & ~in_progress_qq;
    assign events[MsgDone]  = ~in_progress_q & in_progress_qq & ~format_error_q
                              & ~checksum_error_q;
    assign events[MsgFerr]  = format_error_q & ~format_error_qq;
    assign events[MsgCerr]  = checksum_error_q & ~checksum_error_qq;

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        idx_d      = idx_q;
        cur_loc_d  = cur_loc_q;
        clr        = '0;
        byte_valid = 1'b0;
        byte_data  = msg_char(msg_q, idx_q, cur_loc_q);
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    if (pend_q[MsgFerr])      msg_d = MsgFerr;
                    else if (pend_q[MsgCerr]) msg_d = MsgCerr;
                    else if (pend_q[MsgDone]) msg_d = MsgDone;
                    else                      msg_d = MsgStart;
                    clr[msg_d] = 1'b1;
                    idx_d      = '0;
                    cur_loc_d  = (msg_d == MsgCerr) ? cerr_loc_q : ferr_loc_q;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                byte_valid = 1'b1;
                if (byte_ready) state_d = StSend;
            end
            StSend: begin
                // Next char is handed over in the last stop cycle so chars run back-to-back.
                if (byte_ready) begin
                    if (idx_q == msg_len(msg_q) - 3'd1) begin
                        state_d = StIdle;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        byte_valid = 1'b1;
                        byte_data  = msg_char(msg_q, idx_d, cur_loc_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new event in the same cycle as its clear wins, so nothing is dropped.
    assign pend_d     = (pend_q & ~clr) | events;
    assign ferr_loc_d = events[MsgFerr] ? error_location_q : ferr_loc_q;
    assign cerr_loc_d = events[MsgCerr] ? error_location_q : cerr_loc_q;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            in_progress_q     <= 1'b0;
            in_progress_qq    <= 1'b0;
            format_error_q    <= 1'b0;
            format_error_qq   <= 1'b0;
            checksum_error_q  <= 1'b0;
            checksum_error_qq <= 1'b0;
            error_location_q  <= '0;
            state_q           <= StIdle;
            msg_q             <= MsgStart;
            idx_q             <= '0;
            pend_q            <= '0;
            ferr_loc_q        <= '0;
            cerr_loc_q        <= '0;
            cur_loc_q         <= '0;
        end else begin
            in_progress_q     <= in_progress;
            in_progress_qq    <= in_progress_q;
            format_error_q    <= format_error;
            format_error_qq   <= format_error_q;
            checksum_error_q  <= checksum_error;
            checksum_error_qq <= checksum_error_q;
            error_location_q  <= error_location;
            state_q           <= state_d;
            msg_q             <= msg_d;
            idx_q             <= idx_d;
            pend_q            <= pend_d;
            ferr_loc_q        <= ferr_loc_d;
            cerr_loc_q        <= cerr_loc_d;
            cur_loc_q         <= cur_loc_d;
        end
    end

    mfp_uart_transmitter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock     (HCLK),
        .reset     (HRESET),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (UART_TX)
    );

endmodule

// File: tb/tb_mfp_loader_status_reporter.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes and compares.
module tb_mfp_loader_status_reporter;

    localparam int Cpb     = 4;
    localparam int CharLen = 10 * Cpb;

    logic       clk            = 1'b0;
    logic       rst            = 1'b1;
    logic       in_progress    = 1'b0;
    logic       format_error   = 1'b0;
    logic       checksum_error = 1'b0;
    logic [7:0] error_location = 8'h00;
    logic       uart_tx;
    logic       busy;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         rx_count = 0;
    logic       mon_active = 1'b0;
    logic [7:0] exp_q[$];
    int         start_times[$];

    mfp_loader_status_reporter #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .HCLK          (clk),
        .HRESET        (rst),
        .in_progress   (in_progress),
        .format_error  (format_error),
        .checksum_error(checksum_error),
        .error_location(error_location),
        .UART_TX       (uart_tx),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic exp_bytes(input logic [47:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s[8*(n-1-i) +: 8]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || mon_active || exp_q.size() != 0) && n < 2000);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_drain timed out with %0d bytes still required", name, exp_q.size());
        end
        repeat (5) @(negedge clk);
    endtask

    // Start-to-start spacing: one char time inside a message, at most 2 extra at `split`.
    task automatic check_gaps(input string name, input int base, input int n, input int split);
        int d;
        if (start_times.size() < base + n) begin
            checks++;
            errors++;
            $display("FAIL %s_starts got %0d required %0d", name, start_times.size() - base, n);
        end else begin
            for (int i = 1; i < n; i++) begin
                d = start_times[base+i] - start_times[base+i-1];
                if (i == split) begin
                    checks++;
                    if (d < CharLen || d > CharLen + 2) begin
                        errors++;
                        $display("FAIL %s_msg_gap got %0d required %0d..%0d", name, d, CharLen,
                                 CharLen + 2);
                    end
                end else begin
                    check(name, d, CharLen);
                end
            end
        end
    endtask

    // UART monitor: samples mid-bit on falling clock edges.
    initial begin : monitor
        int         cnt;
        logic [7:0] sh;
        logic [7:0] e;
        cnt = 0;
        sh  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (uart_tx == 1'b0) begin
                    mon_active = 1'b1;
                    cnt        = 0;
                    start_times.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == Cpb / 2) begin
                    check("start_bit", int'(uart_tx), 0);
                end else if (cnt >= Cpb + 2 && cnt <= 8 * Cpb + 2 && (cnt % Cpb) == 2) begin
                    sh = {uart_tx, sh[7:1]};
                end else if (cnt == 9 * Cpb + 2) begin
                    check("stop_bit", int'(uart_tx), 1);
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte got 0x%02h required none", sh);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", int'(sh), int'(e));
                    end
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired, simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int base;
        int busy_len;
        int lows;
        int busy_cnt;
        int n;

        // Reset values
        step(3);
        check("reset_tx", int'(uart_tx), 1);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        step(5);
        check("post_reset_tx", int'(uart_tx), 1);
        check("post_reset_busy", int'(busy), 0);

        // 1: START then DONE, first-start latency and in-message spacing
        base = start_times.size();
        t0   = cyc;
        in_progress = 1'b1;
        exp_bytes(48'h4C0D0A, 3);
        step(100);
        in_progress = 1'b0;
        exp_bytes(48'h4F4B0D0A, 4);
        wait_idle("t1");
        check("t1_latency", (start_times.size() > base) ? start_times[base] - t0 : -1, 4);
        check_gaps("t1_l_spacing", base, 3, -1);
        check_gaps("t1_ok_spacing", base + 3, 4, -1);

        // 2: format error, location 0x3A, busy window
        step(1);
        error_location = 8'h3A;
        format_error   = 1'b1;
        exp_bytes(48'h454633410D0A, 6);
        busy_len = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) busy_len++;
            else if (busy_len != 0) break;
        end
        checks++;
        if (busy_len < 238 || busy_len > 242) begin
            errors++;
            $display("FAIL t2_busy_len got %0d required 238..242", busy_len);
        end
        step(1);
        format_error = 1'b0;
        wait_idle("t2");

        // 3: simultaneous errors, priority order and inter-message gap
        step(1);
        base           = start_times.size();
        error_location = 8'h05;
        format_error   = 1'b1;
        checksum_error = 1'b1;
        exp_bytes(48'h454630350D0A, 6);
        exp_bytes(48'h454330350D0A, 6);
        wait_idle("t3");
        check_gaps("t3_spacing", base, 12, 6);
        step(1);
        format_error   = 1'b0;
        checksum_error = 1'b0;
        step(5);

        // 4: two checksum pulses during START coalesce, newest location wins
        in_progress = 1'b1;
        exp_bytes(48'h4C0D0A, 3);
        step(10);
        error_location = 8'h11;
        checksum_error = 1'b1;
        step(3);
        checksum_error = 1'b0;
        step(3);
        error_location = 8'h22;
        checksum_error = 1'b1;
        step(3);
        checksum_error = 1'b0;
        exp_bytes(48'h454332320D0A, 6);
        wait_idle("t4");
        step(1);
        in_progress = 1'b0;
        exp_bytes(48'h4F4B0D0A, 4);
        wait_idle("t4_done");

        // 5: reset in the middle of a data bit of the second char
        step(1);
        base = start_times.size();
        in_progress = 1'b1;
        exp_bytes(48'h4C, 1);
        n = 0;
        while (start_times.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_second_char_started", start_times.size() - base, 2);
        repeat (10) @(negedge clk);
        #2;
        rst         = 1'b1;
        in_progress = 1'b0;
        #1;
        check("t5_reset_tx", int'(uart_tx), 1);
        check("t5_reset_busy", int'(busy), 0);
        step(3);
        rst      = 1'b0;
        lows     = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!uart_tx) lows++;
            if (busy) busy_cnt++;
        end
        check("t5_quiet_tx_low_cycles", lows, 0);
        check("t5_quiet_busy_cycles", busy_cnt, 0);
        check("t5_pending_bytes", exp_q.size(), 0);

        // 6: format error held high yields exactly one message
        step(1);
        n              = rx_count;
        error_location = 8'h7F;
        format_error   = 1'b1;
        exp_bytes(48'h454637460D0A, 6);
        step(1000);
        format_error = 1'b0;
        wait_idle("t6");
        repeat (50) @(negedge clk);
        check("t6_byte_count", rx_count - n, 6);

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
